// File: rtl/ksa.sv
// rtl/ksa.sv - RC4 key-scheduling pass over the shared 256x8 s_mem.
// Optional build macro KSA_SKIP_SELF_SWAP_EN: drop both writes when j == i.
module ksa #(
  parameter int KEY_LEN = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  output logic                 rdy,
  input  logic [8*KEY_LEN-1:0] key,
  output logic [7:0]           addr,
  input  logic [7:0]           rddata,
  output logic [7:0]           wrdata,
  output logic                 wren
);

  localparam int KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

  typedef enum logic [3:0] {
    IDLE, RD_I, WT_I, LT_I, RD_J, WT_J, LT_J, WR_J, WR_I
  } state_t;

  state_t               state;
  logic [8*KEY_LEN-1:0] key_r;
  logic [7:0]           i, j, si, sj;
  logic [7:0]           kb, j_next;
  logic [KW-1:0]        kidx, kidx_next;

  // Byte 0 of the key sits in the most significant byte lane.
  always_comb begin
    kb = key_r[8*KEY_LEN-1 -: 8];
    for (int k = 0; k < KEY_LEN; k++)
      if (kidx == KW'(k)) kb = key_r[8*(KEY_LEN-1-k) +: 8];
  end

  assign j_next    = j + rddata + kb;
  assign kidx_next = (kidx == KW'(KEY_LEN-1)) ? '0 : kidx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rdy    <= 1'b1;
      wren   <= 1'b0;
      addr   <= 8'd0;
      wrdata <= 8'd0;
      i      <= 8'd0;
      j      <= 8'd0;
      si     <= 8'd0;
      sj     <= 8'd0;
      kidx   <= '0;
      key_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            key_r <= key;
            i     <= 8'd0;
            j     <= 8'd0;
            kidx  <= '0;
            addr  <= 8'd0;
            rdy   <= 1'b0;
            state <= RD_I;
          end
        end
        RD_I: state <= WT_I;
        WT_I: state <= LT_I;
        LT_I: begin
          si <= rddata;
          j  <= j_next;
`ifdef KSA_SKIP_SELF_SWAP_EN
          if (j_next == i) begin
            // Self-swap is a no-op on memory: jump straight to the advance step.
            i    <= i + 8'd1;
            addr <= i + 8'd1;
            kidx <= kidx_next;
            if (i == 8'hFF) begin
              rdy   <= 1'b1;
              state <= IDLE;
            end else begin
              state <= RD_I;
            end
          end else begin
            addr  <= j_next;
            state <= RD_J;
          end
`else
          addr  <= j_next;
          state <= RD_J;
`endif
        end
        RD_J: state <= WT_J;
        WT_J: state <= LT_J;
        LT_J: begin
          sj     <= rddata;
          addr   <= j;
          wrdata <= si;
          wren   <= 1'b1;
          state  <= WR_J;
        end
        WR_J: begin
          addr   <= i;
          wrdata <= sj;
          state  <= WR_I;
        end
        WR_I: begin
          // i, addr and kidx wrap to zero after the final iteration.
          wren <= 1'b0;
          i    <= i + 8'd1;
          addr <= i + 8'd1;
          kidx <= kidx_next;
          if (i == 8'hFF) begin
            rdy   <= 1'b1;
            state <= IDLE;
          end else begin
            state <= RD_I;
          end
        end
        default: begin
          state <= IDLE;
          rdy   <= 1'b1;
          wren  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ksa.md
Name: ksa

Overview:
RC4 key-scheduling stage. Sits directly downstream of the `init` block and shares the same 256x8 `s_mem` single-port RAM. `init` fills the memory with s[i]=i. This block then runs the 256-iteration KSA swap pass, keyed by a latched secret key. It uses the same en/rdy handshake as `init`, so top-level sequencing chains `init` -> `ksa` and muxes memory ownership on rdy.

Parameters:
KEY_LEN, 3, key length in bytes; key port width is 8*KEY_LEN; byte 0 is the most significant byte.

Ports:
clk      in   1           system clock (CLOCK_50 at top)
rst_n    in   1           asynchronous active-low reset
en       in   1           start request, sampled only while rdy=1
rdy      out  1           1 = idle, accepting a start
key      in   8*KEY_LEN   secret key, latched on start accept
addr     out  8           s_mem address
rddata   in   8           s_mem q
wrdata   out  8           s_mem write data
wren     out  1           s_mem write enable

Behaviour:
- Reset (async, any time, including mid-run): state=IDLE, rdy=1, wren=0, addr=0, wrdata=0, i=0, j=0, key-index=0.
  - Memory contents after a mid-run reset are undefined; the caller must rerun `init` first.
- Memory timing: addr is registered by the RAM on the clk edge; rddata is valid in the following cycle. The FSM therefore spends one wait cycle per read.
- Start: a clk edge with en=1 & rdy=1 latches key, clears i, j and key-index, and enters RD_I. rdy=0 from that edge.
  - en is ignored while rdy=0; no restart and no queuing.
- FSM per iteration, one cycle per state:
  - RD_I: addr=i, wren=0.
  - WT_I: addr=i held.
  - LT_I: si<=rddata; j<=(j+rddata+kb) mod 256.
  - RD_J: addr=j.
  - WT_J: addr=j held.
  - LT_J: sj<=rddata.
  - WR_J: addr=j, wrdata=si, wren=1.
  - WR_I: addr=i, wrdata=sj, wren=1. If i==255 go to IDLE with rdy=1 on that edge; else i<=i+1 and go to RD_I.
- kb is key byte [key-index]; key-index is a mod-KEY_LEN counter advanced with i. There is no divider.
- All address and j arithmetic is 8-bit, wrapping.
- wren=1 only in WR_J and WR_I. In every other state wren=0 and wrdata holds its last value.
- Self-swap (i==j): with the feature off, both writes are still performed with identical data, giving no net change.
- Latency: 8 cycles per iteration. rdy rises on the 2048th clk edge after the accept edge.
- Output of the block: s_mem holds the KSA permutation when rdy rises.

Optional Feature:
KSA_SKIP_SELF_SWAP_EN
- Defined: in LT_I, if the newly computed j equals i, skip RD_J..WR_I. The FSM goes straight to the increment/termination step (that iteration takes 3 cycles) and issues no writes for it. Total latency = 2048 - 5*(number of self-swap iterations).
- Undefined: fixed 8-cycle iteration as above.
- Final memory contents are identical in both builds.

Test Plan:
1. Assert rst_n=0 then release, en=0 -> rdy=1, wren=0, addr=0; state holds for 20 cycles.
2. Identity memory, key=24'h000000, pulse en -> iteration 0: writes (addr0,data0),(addr0,data0); iteration 1: (addr1,1),(addr1,1); iteration 2: j=3, writes (addr3,data2) then (addr2,data3).
   - With KSA_SKIP_SELF_SWAP_EN: no writes in iterations 0 and 1; first wren is at addr 3 with data 2.
3. Identity memory, key=24'h00033C -> final 256 bytes match a software RC4 KSA model; rdy rises exactly 2048 edges after accept (feature off).
4. Hold en=1 throughout, and change key at cycle 100 of the run -> no restart; result equals the run with the original key; a new run starts only at the edge after rdy=1.
5. rst_n=0 for one cycle at cycle 500 -> rdy=1 and wren=0 immediately (asynchronous), i=j=0. Then rerun `init` + `ksa` with key 00033C -> matches model.
6. Wrap check with key=24'hFFFFFF -> j wraps mod 256 and no addr exceeds 255; result matches model.
